instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage of the five-stage MIPS pipeline: owns the program counter, issues word fetches to instruction memory over a valid/ready request and valid-only response interface, and loads the IF/ID pipeline register. The decode stage consumes this register, and this block takes stall and redirect (jump, branch, jump-register target) back from it. Single outstanding fetch, no branch delay slot.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imemRequestValid`  out  1  fetch request valid.
- `imemRequestReady`  in  1  memory accepts request.
- `imemAddress`  out  32  fetch byte address, word-aligned.
- `imemResponseValid`  in  1  fetched word valid; one cycle per accepted request.
- `imemResponseData`  in  32  fetched instruction word.
- `stall`  in  1  decode cannot accept; hold IF/ID.
- `redirectValid`  in  1  decode resolved a taken jump, branch or jump-register.
- `redirectTarget`  in  32  new PC, word-aligned.
- `idInstruction`  out  32  IF/ID instruction; feeds decode control.
- `idPcPlus4`  out  32  IF/ID fetch address + 4.
- `idValid`  out  1  IF/ID holds a real instruction; 0 means bubble.

## Operation

- Registers:
  - `pc`: next address to request.
  - `fetchPc`: address of the outstanding or held fetch.
  - `heldInstruction`: one-entry skid buffer.
  - `dropPending`: outstanding response must be discarded.
  - State: `REQ`, `WAIT`, `HELD`.
- `REQ`:
  - `imemRequestValid = !redirectValid`; `imemAddress = pc`.
  - Redirect: `pc <= redirectTarget`, stay `REQ`.
  - Else on `imemRequestValid && imemRequestReady`: `fetchPc <= pc`, `pc <= pc + 4`, `dropPending <= 0`, go to `WAIT`.
- `WAIT`:
  - No request issued.
  - Redirect without response: `pc <= redirectTarget`, `dropPending <= 1`, stay `WAIT`.
  - Response with `dropPending` or `redirectValid`: discard the word, go to `REQ`. On redirect also `pc <= redirectTarget`.
  - Response, no stall: load IF/ID with `{imemResponseData, fetchPc + 4, valid = 1}`, go to `REQ`.
  - Response with stall: `heldInstruction <= imemResponseData`, go to `HELD`.
- `HELD`:
  - Redirect: discard the buffer, `pc <= redirectTarget`, go to `REQ`.
  - Else when `!stall`: load IF/ID from the buffer, go to `REQ`.
- IF/ID update priority:
  1. `redirectValid`: `idValid <= 0`, flush.
  2. `stall`: hold all three fields.
  3. Load: `idValid <= 1`.
  4. Otherwise: `idValid <= 0`, bubble. Instruction and PC fields are left unchanged.
- Arithmetic: PC adds are 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of the PC are never changed by this block.

## Timing

- Reset values:
  - State `REQ`, `pc = RESET_PC`, `dropPending = 0`.
  - `idValid = 0`, `idInstruction = 32'h0000_0000` (NOP), `idPcPlus4 = 0`.
  - `imemRequestValid = 1` and `imemAddress = RESET_PC` while reset is asserted and no redirect is present.
- Request outputs are combinational from state, `pc` and `redirectValid`. Everything else is registered.
- A response arrives at least 1 cycle after acceptance; same-cycle response is illegal. Latency is unbounded.
- Best case: one instruction per 2 cycles. Accept in cycle N, response in N+1, IF/ID valid in N+2.
- Redirect in cycle N: IF/ID is a bubble in N+1, and the first request to the target appears in N+1 at the earliest.
- Reset asserted mid-fetch:
  - All state clears immediately.
  - A late response for the pre-reset request is not tracked. The memory must be reset together with this block.

## Structure

- Add to `Constants.vh`:
  - `` `INSTRUCTION_NOP `` = 32'h0000_0000.
  - `` `FETCH_STATE_REQ ``, `` `FETCH_STATE_WAIT ``, `` `FETCH_STATE_HELD `` (2-bit encodings).
- Natural sub-module: `if_id_register`. It holds the three IF/ID fields and implements the flush, stall, load and bubble priority.

## Test plan

- Reset with `RESET_PC` = 32'h0000_0100, memory ready, 1-cycle latency: addresses 0x100, 0x104, 0x108 are requested on alternate cycles; `idPcPlus4` takes 0x104, 0x108, 0x10C with `idValid` pulsing high every second cycle.
- Stall held for 3 cycles while a response arrives: state goes to `HELD` and IF/ID is unchanged. After stall drops, IF/ID shows the buffered word for one cycle, then the next request issues.
- Redirect to 0x400 in `WAIT` before the response (latency 3): that response is discarded, `idValid` = 0, and the next request address is 0x400.
- Redirect to 0x800 with stall in the same cycle while in `HELD`: `idValid` goes to 0 and the buffer is dropped; the next request is 0x800.
- `imemRequestReady` low for 5 cycles: the request stays asserted at a stable address, `pc` does not advance and `idValid` stays 0.
- PC 32'hFFFF_FFFC accepted: the next request address is 32'h0000_0000, and `idPcPlus4` = 0 for that instruction.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction fetch stage: fetch FSM state
// encoding, the NOP encoding used to clear IF/ID, and the PC increment helper.
package instruction_fetch_stage_pkg;

    // Encoding of an all-zero word; sll $0,$0,0 is the canonical MIPS NOP.
    localparam logic [31:0] INSTRUCTION_NOP = 32'h0000_0000;

    // Fetch controller states.
    //   REQ  : offering a request for pc to instruction memory
    //   WAIT : one request accepted, response not yet seen
    //   HELD : response arrived while decode was stalled; word sits in the skid buffer
    typedef enum logic [1:0] {
        FETCH_STATE_REQ  = 2'd0,
        FETCH_STATE_WAIT = 2'd1,
        FETCH_STATE_HELD = 2'd2
    } fetch_state_t;

    // Next sequential word address. Only the word index is incremented, so the
    // byte-offset bits pass through untouched and the add wraps modulo 2^32.
    function automatic logic [31:0] pc_add4(input logic [31:0] pc);
        return {pc[31:2] + 30'd1, pc[1:0]};
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register. Holds the fetched instruction, its PC+4 and a
// valid flag, updated with priority flush > stall > load > bubble.
module instruction_fetch_stage_if_id_register
    import instruction_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic [31:0] load_instruction,
    input  logic [31:0] load_pc_plus4,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    // Flush and bubble only clear valid; the payload fields keep their last
    // contents so decode sees stable (if meaningless) data under a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= INSTRUCTION_NOP;
            pc_plus4    <= 32'h0000_0000;
            valid       <= 1'b0;
        end else if (flush) begin
            valid       <= 1'b0;
        end else if (stall) begin
            valid       <= valid;
        end else if (load) begin
            instruction <= load_instruction;
            pc_plus4    <= load_pc_plus4;
            valid       <= 1'b1;
        end else begin
            valid       <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage of the five-stage MIPS pipeline. Owns the PC, keeps at most one
// fetch outstanding to instruction memory, buffers a returned word while decode
// stalls, and honours redirects (jump/branch/jr) coming back from decode.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemRequestValid,
    input  logic        imemRequestReady,
    output logic [31:0] imemAddress,
    input  logic        imemResponseValid,
    input  logic [31:0] imemResponseData,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic [31:0] idInstruction,
    output logic [31:0] idPcPlus4,
    output logic        idValid
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  fetch_pc;
    logic [31:0]  held_instruction;
    logic         drop_pending;

    logic         request_fire;
    logic         response_kept;
    logic         load_from_memory;
    logic         load_from_buffer;
    logic         load;
    logic [31:0]  load_instruction;
    logic [31:0]  load_pc_plus4;

    // A redirect suppresses the request in the same cycle so the stale pc is
    // never sent; the new target goes out on the following cycle.
    assign imemRequestValid = (state == FETCH_STATE_REQ) && !redirectValid;
    assign imemAddress      = pc;
    assign request_fire     = imemRequestValid && imemRequestReady;

    // A response is useful only if no redirect has overtaken it.
    assign response_kept    = (state == FETCH_STATE_WAIT) && imemResponseValid
                              && !drop_pending && !redirectValid;
    assign load_from_memory = response_kept && !stall;
    assign load_from_buffer = (state == FETCH_STATE_HELD) && !redirectValid && !stall;
    assign load             = load_from_memory || load_from_buffer;
    assign load_instruction = load_from_buffer ? held_instruction : imemResponseData;
    assign load_pc_plus4    = pc_add4(fetch_pc);

    // Fetch controller: PC sequencing, outstanding-fetch tracking and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= FETCH_STATE_REQ;
            pc               <= RESET_PC;
            fetch_pc         <= RESET_PC;
            held_instruction <= INSTRUCTION_NOP;
            drop_pending     <= 1'b0;
        end else begin
            case (state)
                FETCH_STATE_REQ: begin
                    if (redirectValid) begin
                        pc <= redirectTarget;
                    end else if (request_fire) begin
                        fetch_pc     <= pc;
                        pc           <= pc_add4(pc);
                        drop_pending <= 1'b0;
                        state        <= FETCH_STATE_WAIT;
                    end
                end
                FETCH_STATE_WAIT: begin
                    if (imemResponseValid) begin
                        if (redirectValid) begin
                            pc <= redirectTarget;
                        end
                        if (drop_pending || redirectValid || !stall) begin
                            state <= FETCH_STATE_REQ;
                        end else begin
                            held_instruction <= imemResponseData;
                            state            <= FETCH_STATE_HELD;
                        end
                    end else if (redirectValid) begin
                        // The in-flight word belongs to the old path; remember to
                        // throw it away when it finally shows up.
                        pc           <= redirectTarget;
                        drop_pending <= 1'b1;
                    end
                end
                FETCH_STATE_HELD: begin
                    if (redirectValid) begin
                        pc    <= redirectTarget;
                        state <= FETCH_STATE_REQ;
                    end else if (!stall) begin
                        state <= FETCH_STATE_REQ;
                    end
                end
                default: begin
                    state <= FETCH_STATE_REQ;
                end
            endcase
        end
    end

    instruction_fetch_stage_if_id_register u_if_id (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (redirectValid),
        .stall            (stall),
        .load             (load),
        .load_instruction (load_instruction),
        .load_pc_plus4    (load_pc_plus4),
        .instruction      (idInstruction),
        .pc_plus4         (idPcPlus4),
        .valid            (idValid)
    );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: random memory latency/readiness, stalls
// and redirects; a program-order reference model feeds a scoreboard queue.
module tb_instruction_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imemRequestValid;
    logic        imemRequestReady;
    logic [31:0] imemAddress;
    logic        imemResponseValid;
    logic [31:0] imemResponseData;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic [31:0] idInstruction;
    logic [31:0] idPcPlus4;
    logic        idValid;

    instruction_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imemRequestValid  (imemRequestValid),
        .imemRequestReady  (imemRequestReady),
        .imemAddress       (imemAddress),
        .imemResponseValid (imemResponseValid),
        .imemResponseData  (imemResponseData),
        .stall             (stall),
        .redirectValid     (redirectValid),
        .redirectTarget    (redirectTarget),
        .idInstruction     (idInstruction),
        .idPcPlus4         (idPcPlus4),
        .idValid           (idValid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: expected program-order fetch addresses for IF/ID,
    // and the expected address of the next accepted memory request.
    logic [31:0] exp_q[$];
    logic [31:0] exp_req;

    // Memory model: single outstanding request with a countdown.
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    bit          rate_phase = 1'b0;
    int          last_new = -1;
    int          consumed = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit pct(input int p);
        return ($urandom_range(0, 99) < p);
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0400;
            1:       return 32'h0000_0800;
            2:       return 32'hFFFF_FFF8;
            3:       return 32'hFFFF_FFFC;
            default: return $urandom & 32'h0000_3FFC;
        endcase
    endfunction

    // One cycle of stimulus, driven at the falling edge; request acceptance is
    // observed just after the drive, which is what the next rising edge uses.
    task automatic drive_cycle(input int rdy_pct, input int stall_pct,
                               input int redir_pct, input int lat_max);
        logic [31:0] t;
        @(negedge clk);
        imemResponseValid = 1'b0;
        imemResponseData  = $urandom;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imemResponseValid = 1'b1;
                imemResponseData  = word_of(pend_addr);
                pend = 1'b0;
            end
        end
        imemRequestReady = pct(rdy_pct);
        stall            = pct(stall_pct);
        redirectValid    = pct(redir_pct);
        if (redirectValid) begin
            t = pick_target();
            redirectTarget = t;
            exp_q.delete();
            exp_q.push_back(t);
            exp_req = t;
        end else begin
            redirectTarget = $urandom & 32'hFFFF_FFFC;
        end
        #1;
        if (redirectValid)
            check(imemRequestValid == 1'b0, "req_suppressed_on_redirect",
                  {31'h0, imemRequestValid}, 32'h0);
        if (imemRequestValid && imemRequestReady) begin
            check(pend == 1'b0, "single_outstanding", {31'h0, pend}, 32'h0);
            check(imemAddress == exp_req, "request_address", imemAddress, exp_req);
            pend      = 1'b1;
            pend_cnt  = $urandom_range(1, lat_max);
            pend_addr = imemAddress;
            exp_req   = imemAddress + 32'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n             = 1'b0;
        imemRequestReady  = 1'b0;
        imemResponseValid = 1'b0;
        imemResponseData  = 32'h0;
        stall             = 1'b0;
        redirectValid     = 1'b0;
        redirectTarget    = 32'h0;
        pend              = 1'b0;
        exp_q.delete();
        #1;
        check(idValid == 1'b0, "reset_idValid", {31'h0, idValid}, 32'h0);
        check(imemAddress == RESET_PC, "reset_address", imemAddress, RESET_PC);
        @(negedge clk);
        check(idInstruction == 32'h0, "reset_idInstruction", idInstruction, 32'h0);
        check(idPcPlus4 == 32'h0, "reset_idPcPlus4", idPcPlus4, 32'h0);
        check(imemRequestValid == 1'b1, "reset_request_valid", {31'h0, imemRequestValid}, 32'h1);
        rst_n = 1'b1;
        exp_q.push_back(RESET_PC);
        exp_req = RESET_PC;
    endtask

    // Monitor: after each rising edge, compare IF/ID against the scoreboard.
    initial begin
        int cyc = 0;
        int idle = 0;
        logic [31:0] snap_i = 32'h0;
        logic [31:0] snap_p = 32'h0;
        logic        snap_v = 1'b0;
        logic [31:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1) begin
                cyc++;
                idle++;
                if (redirectValid) begin
                    check(idValid == 1'b0, "flush_bubble", {31'h0, idValid}, 32'h0);
                    idle = 0;
                end else if (stall) begin
                    check(idValid == snap_v, "stall_hold_valid", {31'h0, idValid}, {31'h0, snap_v});
                    check(idInstruction == snap_i, "stall_hold_instr", idInstruction, snap_i);
                    check(idPcPlus4 == snap_p, "stall_hold_pc4", idPcPlus4, snap_p);
                end else if (idValid) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_instruction", idPcPlus4, 32'h0);
                    end else begin
                        a = exp_q.pop_front();
                        check(idPcPlus4 == a + 32'd4, "idPcPlus4", idPcPlus4, a + 32'd4);
                        check(idInstruction == word_of(a), "idInstruction", idInstruction, word_of(a));
                        exp_q.push_back(a + 32'd4);
                        if (rate_phase && last_new >= 0)
                            check(cyc - last_new == 2, "issue_rate",
                                  cyc - last_new, 32'd2);
                        last_new = cyc;
                        consumed++;
                        idle = 0;
                    end
                end
                if (idle > 150) begin
                    check(1'b0, "progress_timeout", idle, 32'd150);
                    idle = 0;
                end
            end
            snap_i = idInstruction;
            snap_p = idPcPlus4;
            snap_v = idValid;
        end
    end

    // Stimulus: reset, ready-low hold, best-case throughput, random traffic,
    // a mid-run reset, then more random traffic.
    initial begin
        rst_n             = 1'b0;
        imemRequestReady  = 1'b0;
        imemResponseValid = 1'b0;
        imemResponseData  = 32'h0;
        stall             = 1'b0;
        redirectValid     = 1'b0;
        redirectTarget    = 32'h0;
        exp_req           = RESET_PC;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 0, 0, 1);
            check(imemRequestValid == 1'b1, "not_ready_req_held", {31'h0, imemRequestValid}, 32'h1);
            check(imemAddress == RESET_PC, "not_ready_addr_stable", imemAddress, RESET_PC);
            check(idValid == 1'b0, "not_ready_no_output", {31'h0, idValid}, 32'h0);
        end

        last_new   = -1;
        rate_phase = 1'b1;
        for (int i = 0; i < 12; i++) drive_cycle(100, 0, 0, 1);
        @(negedge clk);
        rate_phase = 1'b0;
        check(consumed >= 5, "best_case_count", consumed, 32'd5);

        for (int i = 0; i < 1500; i++) drive_cycle(70, 30, 6, 4);

        do_reset();
        for (int i = 0; i < 1500; i++) drive_cycle(85, 20, 4, 3);

        @(negedge clk);
        check(consumed >= 200, "total_consumed", consumed, 32'd200);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
